// File: rtl/mp_arith_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mp_arith_pkg: shared state encoding, mode constants and width check for the
// multi-precision add/sub datapath.  rev 1.0
// ---------------------------------------------------------------------------
package mp_arith_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic bit widths_ok(input int unsigned ow, input int unsigned aw);
    return (aw != 0) && (ow >= aw) && ((ow % aw) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mp_word_addsub.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mp_word_addsub: one combinational word slice; b is inverted when sub=1.
// rev 1.0
// ---------------------------------------------------------------------------
module mp_word_addsub #(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   total;

  assign b_eff = b ^ {WIDTH{sub}};
  assign total = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
  assign sum   = total[WIDTH-1:0];
  assign cout  = total[WIDTH];

endmodule
`default_nettype wire

// File: rtl/mp_addsub_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mp_addsub_stream: iterative word-serial multi-precision adder/subtractor
// with valid/ready on both sides, borrow and zero flags.  rev 1.0
// ---------------------------------------------------------------------------
module mp_addsub_stream
  import mp_arith_pkg::*;
#(
  parameter int OPERAND_WIDTH = 1024,
  parameter int ADDER_WIDTH   = 128
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iValid,
  output logic                     oReady,
  input  logic                     iSub,
  input  logic [OPERAND_WIDTH-1:0] iOpA,
  input  logic [OPERAND_WIDTH-1:0] iOpB,
  output logic [OPERAND_WIDTH:0]   oRes,
  output logic                     oZero,
  output logic                     oValid,
  input  logic                     iReady,
  output logic                     oBusy
);

  localparam int N_ITERATIONS = OPERAND_WIDTH / ADDER_WIDTH;
  localparam int CNT_W        = $clog2(N_ITERATIONS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITERATIONS - 1);

  generate
    if (!widths_ok(OPERAND_WIDTH, ADDER_WIDTH)) begin : g_bad_widths
      $error("mp_addsub_stream: OPERAND_WIDTH must be a multiple of ADDER_WIDTH");
    end
  endgenerate

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [OPERAND_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [ADDER_WIDTH-1:0]   acc_q, acc_d;
  logic                     sub_q, sub_d, carry_q, carry_d, msb_q, msb_d;
  logic                     zero_q, zero_d, valid_q, valid_d, busy_q, busy_d;

  logic [ADDER_WIDTH-1:0]               word_sum;
  logic                                 word_cout;
  logic                                 word_cin;
  logic [OPERAND_WIDTH+ADDER_WIDTH-1:0] res_shift;

  assign word_cin  = (cnt_q == '0) ? sub_q : carry_q;
  // New sum word enters at the top; after N_ITERATIONS words the LSW sits at bit 0.
  assign res_shift = {word_sum, res_q} >> ADDER_WIDTH;

  mp_word_addsub #(
    .WIDTH (ADDER_WIDTH)
  ) u_slice (
    .a    (a_q[ADDER_WIDTH-1:0]),
    .b    (b_q[ADDER_WIDTH-1:0]),
    .cin  (word_cin),
    .sub  (sub_q),
    .sum  (word_sum),
    .cout (word_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    acc_d   = acc_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    msb_d   = msb_q;
    zero_d  = zero_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (iValid) begin
          a_d     = iOpA;
          b_d     = iOpB;
          sub_d   = iSub;
          res_d   = '0;
          acc_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
          msb_d   = 1'b0;
          zero_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        a_d     = a_q >> ADDER_WIDTH;
        b_d     = b_q >> ADDER_WIDTH;
        res_d   = res_shift[OPERAND_WIDTH-1:0];
        acc_d   = acc_q | word_sum;
        carry_d = word_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          msb_d   = (sub_q == OP_SUB) ? ~word_cout : word_cout;
          zero_d  = ~|(acc_q | word_sum);
          valid_d = 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (iReady) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      msb_q   <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      msb_q   <= msb_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign oReady = (state_q == S_IDLE);
  assign oRes   = {msb_q, res_q};
  assign oZero  = zero_q;
  assign oValid = valid_q;
  assign oBusy  = busy_q;

endmodule
`default_nettype wire
